booth_r4_mul: RTL
=================

// Module: booth_r4_mul
// PURPOSE
//  Parametrised sequential radix-4 Booth multiplier; next generation of the radix-2 Booth datapath.
//  - Retires 2 multiplier bits per cycle.
//  - Supports signed and unsigned operands.
//  - Uses an explicit start/busy/done handshake to the top-level controller.
//  - Computes result = multiplier * multiplicand at full 2*WIDTH precision.
// PARAMETERS
//  WIDTH  64  operand width; even, >= 4; result is 2*WIDTH bits
// PORTS
//  clk           in   1        clock; all state changes on rising edge
//  reset         in   1        synchronous, active-high reset
//  op_start      in   1        request new multiply; sampled only in IDLE or DONE
//  op_clear      in   1        synchronous abort/clear; priority over op_start
//  signed_mode   in   1        1: two's-complement operands; 0: unsigned; sampled with op_start
//  multiplier    in   WIDTH    operand, sampled on the accepting edge
//  multiplicand  in   WIDTH    operand, sampled on the accepting edge
//  op_busy       out  1        1 while state == MUL
//  op_done       out  1        1 while state == DONE; result valid
//  result        out  2*WIDTH  product register
// BEHAVIOUR
//  - Reset:
//    - reset=1 at a clock edge: state=IDLE, op_busy=0, op_done=0, result=0, internal registers=0.
//    - Overrides everything, including mid-operation.
//  - States IDLE, MUL, DONE.
//    - IDLE/DONE + op_start & !op_clear -> MUL: operands latched; step counter=0; op_done drops.
//    - MUL -> DONE after the final step.
//    - DONE holds until op_start or op_clear.
//    - op_clear in any state: -> IDLE; result=0; op_done=0; any operation in flight is discarded.
//  - op_start while MUL: ignored; no queueing.
//  - op_start & op_clear in the same cycle: clear wins; start is dropped.
//  - Operand extension:
//    - Both operands extended to WIDTH+2 bits: sign-extended if signed_mode=1, zero-extended if 0.
//    - Steps N = WIDTH/2+1 (33 at WIDTH=64).
//  - Step (one per MUL cycle): digit from {q[1],q[0],q_m1}:
//    - 000/111 -> 0
//    - 001/010 -> +M
//    - 011 -> +2M
//    - 100 -> -2M
//    - 101/110 -> -M
//    - Accumulate into the high half, then arithmetic-shift {acc,q,q_m1} right by 2.
//    - Accumulator has WIDTH+4 bits; no intermediate overflow is permitted.
//    - -M and -2M are formed as ~x + 1 via the carry-in of a single adder.
//  - Latency: op_done high after N+1 edges counted from the accepting edge.
//    - Accepting edge counts as 1; WIDTH=64 gives 34.
//  - result:
//    - Written only on the MUL->DONE edge, with the low 2*WIDTH bits of the product.
//    - Otherwise holds its value; a new start does not clear it.
//  - Operand inputs may change freely after the accepting edge.
// CONFIGURATION
//  BOOTH_EARLY_TERM_EN
//    - Defined:
//      - After each step, if the unprocessed multiplier bits and q_m1 are all equal, all remaining digits are 0.
//      - The block then arithmetic-shifts the partial product right by 2*(remaining steps) in the same edge and enters DONE.
//      - Latency is variable, between 2 and N+1 edges.
//    - Undefined: fixed latency of N+1 edges; the early-termination logic is absent.
// TESTING
//  1. signed_mode=1, multiplier=-3, multiplicand=7 -> op_done at edge 34, result=128'hFFFF_..._FFEB (-21).
//  2. signed_mode=0, both=64'hFFFF_FFFF_FFFF_FFFF -> result=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
//  3. signed_mode=1, both=64'h8000_0000_0000_0000 -> result=128'h4000_0000_..._0000 (2^126), no overflow.
//  4. Start 5*3, op_clear at step 10 -> next cycle IDLE, op_done=0, result=0; op_start pulses during MUL ignored.
//  5. DONE with result=15, then new op_start(2*2) -> op_done drops, result stays 15 until the new op_done, then becomes 4.
//  6. BOOTH_EARLY_TERM_EN, signed 5*3 -> op_done after 3 edges, result=15; undefined -> 34 edges, same result.

Source files
------------

// File: rtl/booth_r4_mul_if.sv
// booth_r4_mul_if: operand/handshake bundle for the radix-4 Booth multiplier.
// master drives requests and operands; slave returns status and product.
interface booth_r4_mul_if #(
  parameter int WIDTH = 64
);
  logic               op_start;
  logic               op_clear;
  logic               signed_mode;
  logic [WIDTH-1:0]   multiplier;
  logic [WIDTH-1:0]   multiplicand;
  logic               op_busy;
  logic               op_done;
  logic [2*WIDTH-1:0] result;

  modport master (
    output op_start, op_clear, signed_mode,
    output multiplier, multiplicand,
    input  op_busy, op_done, result
  );

  modport slave (
    input  op_start, op_clear, signed_mode,
    input  multiplier, multiplicand,
    output op_busy, op_done, result
  );
endinterface

// File: rtl/booth_r4_mul.sv
// booth_r4_mul: sequential radix-4 Booth multiplier, two multiplier bits per cycle.
// Define BOOTH_EARLY_TERM_EN to finish as soon as all remaining digits are zero.
module booth_r4_mul #(
  parameter int WIDTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  booth_r4_mul_if.slave bus
);
  localparam int QW = WIDTH + 2;
  localparam int AW = WIDTH + 4;
  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e             state_q;
  logic [QW-1:0]      m_q;
  logic [QW-1:0]      q_q;
  logic [AW-1:0]      acc_q;
  logic               qm1_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] res_q;

  logic [QW-1:0]      mcand_x;
  logic [QW-1:0]      mplier_x;
  logic [AW-1:0]      m_ext;
  logic [AW-1:0]      addend;
  logic               neg;
  logic [AW-1:0]      sum;
  logic [AW-1:0]      acc_d;
  logic [QW-1:0]      q_d;
  logic               qm1_d;
  logic               fin;
  logic [2*WIDTH-1:0] prod_d;

  assign mcand_x = bus.signed_mode
    ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
    : {2'b00, bus.multiplicand};
  assign mplier_x = bus.signed_mode
    ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
    : {2'b00, bus.multiplier};

  assign m_ext = {{2{m_q[QW-1]}}, m_q};

  // Negative digits invert here and add one through the adder carry-in.
  always_comb begin
    addend = '0;
    neg    = 1'b0;
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_ext << 1;
      3'b100: begin
        addend = ~(m_ext << 1);
        neg    = 1'b1;
      end
      3'b101, 3'b110: begin
        addend = ~m_ext;
        neg    = 1'b1;
      end
      default: addend = '0;
    endcase
  end

  assign sum   = acc_q + addend + AW'(neg);
  assign acc_d = {{2{sum[AW-1]}}, sum[AW-1:2]};
  assign q_d   = {sum[1:0], q_q[QW-1:2]};
  assign qm1_d = q_q[1];

`ifdef BOOTH_EARLY_TERM_EN
  logic [CW-1:0] rem;
  logic [CW:0]   shamt;

  assign rem   = CW'(N - 1) - cnt_q;
  assign shamt = {rem, 1'b0};

  // Unprocessed bits all equal to q_m1 means every later digit is zero.
  always_comb begin
    fin = 1'b1;
    for (int i = 0; i < QW; i++) begin
      if (i < 2 * int'(rem) && q_d[i] != qm1_d) fin = 1'b0;
    end
  end

  assign prod_d = (2*WIDTH)'($signed({acc_d, q_d}) >>> shamt);
`else
  assign fin    = cnt_q == CW'(N - 1);
  assign prod_d = {acc_d[WIDTH-3:0], q_d};
`endif

  always_ff @(posedge clk) begin
    if (reset || bus.op_clear) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.op_start) begin
            state_q <= MUL;
            m_q     <= mcand_x;
            q_q     <= mplier_x;
            acc_q   <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        MUL: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + CW'(1);
          if (fin) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            res_q   <= prod_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.op_busy = busy_q;
  assign bus.op_done = done_q;
  assign bus.result  = res_q;
endmodule
